timebase_scheduler: RTL

- Shares one free-running prescaler among NUM_CH independent timer channels.
- The prescaler derives a base tick from the system clock. Each channel counts base ticks against its own programmable period and emits one-cycle tick pulses plus a toggling square-wave level.
- Software and FSM logic start, stop and reprogram channels through a valid/ready config port.
- Replaces per-consumer 1 Hz divider instances (display refresh, game timers, stopwatch).

---
 rtl/timebase_pkg.sv | 17 +
 rtl/timebase_channel.sv | 78 +++++++
 rtl/timebase_scheduler.sv | 91 +++++++++
 3 files changed

// File: rtl/timebase_pkg.sv
// Shared encodings for the timebase scheduler: config opcodes and channel FSM states.
package timebase_pkg;

    typedef enum logic [1:0] {
        OP_STOP           = 2'b00,
        OP_START_ONESHOT  = 2'b01,
        OP_START_PERIODIC = 2'b10,
        OP_SET_PERIOD     = 2'b11
    } cfg_op_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUN_ONE = 2'b01,
        RUN_PER = 2'b10
    } ch_state_e;

endpackage

// File: rtl/timebase_channel.sv
// One timer channel: counts shared base ticks against its own period and
// emits an expiry pulse plus a toggling level.
module timebase_channel
    import timebase_pkg::*;
#(
    parameter int PER_W       = 16,
    parameter int PER_DEFAULT = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             base_tick,
    input  logic             apply,
    input  cfg_op_e          op,
    input  logic [PER_W-1:0] period_in,
    output logic             tick,
    output logic             level,
    output logic             busy
);

    ch_state_e        state;
    logic [PER_W-1:0] cnt;
    logic [PER_W-1:0] period;
    logic [PER_W-1:0] new_period;

    // A zero period would never match cnt == period-1 before wrapping, so clamp it.
    function automatic logic [PER_W-1:0] sat_period(input logic [PER_W-1:0] p);
        return (p == '0) ? PER_W'(1) : p;
    endfunction

    assign new_period = sat_period(period_in);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            period <= PER_W'(PER_DEFAULT);
            tick   <= 1'b0;
            level  <= 1'b0;
        end else begin
            tick <= 1'b0;
            // A command landing on a base-tick edge takes priority; that tick is dropped.
            if (apply) begin
                case (op)
                    OP_STOP: begin
                        state <= IDLE;
                        cnt   <= '0;
                        level <= 1'b0;
                    end
                    OP_START_ONESHOT: begin
                        state <= RUN_ONE;
                        cnt   <= '0;
                    end
                    OP_START_PERIODIC: begin
                        state <= RUN_PER;
                        cnt   <= '0;
                    end
                    OP_SET_PERIOD: begin
                        period <= new_period;
                        if (state != IDLE && cnt >= new_period)
                            cnt <= '0;
                    end
                endcase
            end else if (state != IDLE && base_tick) begin
                if (cnt == period - PER_W'(1)) begin
                    tick  <= 1'b1;
                    level <= ~level;
                    cnt   <= '0;
                    if (state == RUN_ONE)
                        state <= IDLE;
                end else begin
                    cnt <= cnt + PER_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/timebase_scheduler.sv
// Shared prescaler plus NUM_CH programmable timer channels behind a
// valid/ready config port with a one-entry command stage.
module timebase_scheduler
    import timebase_pkg::*;
#(
    parameter  int CLK_HZ      = 100000000,
    parameter  int BASE_HZ     = 1000,
    parameter  int NUM_CH      = 4,
    parameter  int PER_W       = 16,
    parameter  int PER_DEFAULT = 1000,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [1:0]        cfg_op,
    input  logic [PER_W-1:0]  cfg_period,
    output logic              base_tick_o,
    output logic [NUM_CH-1:0] tick_o,
    output logic [NUM_CH-1:0] level_o,
    output logic [NUM_CH-1:0] busy_o
);

    localparam int DIV  = CLK_HZ / BASE_HZ;
    localparam int PS_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PS_W-1:0]  ps_cnt;
    logic [PS_W-1:0]  ps_next;
    logic             accept;
    logic             vld_p0;
    logic [CH_W-1:0]  ch_p0;
    cfg_op_e          op_p0;
    logic [PER_W-1:0] per_p0;

    assign ps_next = (ps_cnt == PS_W'(DIV - 1)) ? '0 : ps_cnt + PS_W'(1);
    assign accept  = cfg_valid & cfg_ready;

    // Pulse is registered so it is high exactly while the count sits at DIV-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_cnt      <= '0;
            base_tick_o <= 1'b0;
        end else begin
            ps_cnt      <= ps_next;
            base_tick_o <= (ps_next == PS_W'(DIV - 1));
        end
    end

    // Stage p0: command capture; ready drops for the cycle after each accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_ready <= 1'b1;
            vld_p0    <= 1'b0;
        end else begin
            cfg_ready <= ~accept;
            vld_p0    <= accept;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            ch_p0  <= cfg_ch;
            op_p0  <= cfg_op_e'(cfg_op);
            per_p0 <= cfg_period;
        end
    end

    // Stage p1: apply; an out-of-range channel index matches no instance and is dropped.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic apply;
        assign apply = vld_p0 && (ch_p0 == CH_W'(i));

        timebase_channel #(
            .PER_W      (PER_W),
            .PER_DEFAULT(PER_DEFAULT)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .base_tick(base_tick_o),
            .apply    (apply),
            .op       (op_p0),
            .period_in(per_p0),
            .tick     (tick_o[i]),
            .level    (level_o[i]),
            .busy     (busy_o[i])
        );
    end

endmodule
